// File: rtl/spi_master_param.sv
// Register-mapped SPI master: programmable CPOL/CPHA, bit order, word length and clock divider.
// Optional internal loopback (CTRL bit3) is compiled in with `define SPI_LOOPBACK_EN.
module spi_master_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int N_SS   = 4,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic [ADDR_W-1:0] address,
    input  logic              sel,
    input  logic              read,
    input  logic              write,
    output logic              sclk,
    output logic [N_SS-1:0]   ss,
    output logic              mosi,
    input  logic              miso
);
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int EDGE_W = CNT_W + 1;

    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_DIV  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TX   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_RX   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_LEN  = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_SRST = ADDR_W'(6);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t              r_state;
    logic                r_cpol, r_cpha, r_lsb;
    logic [3:0]          r_ss_idx;
    logic [DIV_W-1:0]    r_div, r_cnt;
    logic [DATA_W-1:0]   r_len, r_rx, r_tx, r_rx_sh;
    logic                r_rx_valid, r_overrun;
    logic                r_sclk, r_mosi;
    logic [N_SS-1:0]     r_ss;
    logic [EDGE_W-1:0]   r_edges;
    logic [CNT_W-1:0]    r_len_eff;

    logic                w_wr, w_rd, w_srst, w_busy, w_loop, w_rx_in;
    logic [CNT_W-1:0]    w_len;
    logic [DATA_W-1:0]   w_tx_init, w_tx_next, w_rx_aligned, w_ctrl;
    logic                w_first, w_tx_bit, w_half_end, w_last, w_lead, w_sample;
    logic [EDGE_W-1:0]   w_edge_no;
    logic [3:0]          w_ss_idx;

`ifdef SPI_LOOPBACK_EN
    logic r_loop;
    assign w_loop  = r_loop;
    assign w_rx_in = r_loop ? r_mosi : miso;
`else
    assign w_loop  = 1'b0;
    assign w_rx_in = miso;
`endif

    assign w_wr   = sel & write;
    assign w_rd   = sel & read;
    assign w_srst = rst | (w_wr && address == A_SRST);
    assign w_busy = (r_state != IDLE);

    assign w_len     = (r_len == '0 || r_len > DATA_W'(DATA_W)) ? CNT_W'(DATA_W) : CNT_W'(r_len);
    // MSB-first words are left-aligned so the shifter always emits from the top bit
    assign w_tx_init = r_lsb ? data_in : (data_in << (DATA_W - int'(w_len)));
    assign w_first   = r_lsb ? w_tx_init[0] : w_tx_init[DATA_W-1];
    assign w_tx_bit  = r_lsb ? r_tx[0] : r_tx[DATA_W-1];
    assign w_tx_next = r_lsb ? (r_tx >> 1) : (r_tx << 1);

    assign w_half_end = (r_cnt == '0);
    assign w_last     = (r_edges == {r_len_eff, 1'b0});
    assign w_edge_no  = r_edges + EDGE_W'(1);
    assign w_lead     = w_edge_no[0];
    assign w_sample   = r_cpha ? ~w_lead : w_lead;
    assign w_ss_idx   = (int'(r_ss_idx) >= N_SS) ? 4'd0 : r_ss_idx;

    // LSB-first data enters at the top, so slide it down to bit 0
    assign w_rx_aligned = r_lsb ? (r_rx_sh >> (DATA_W - int'(r_len_eff))) : r_rx_sh;
    assign w_ctrl       = DATA_W'({r_ss_idx, w_loop, r_lsb, r_cpha, r_cpol});

    assign sclk = r_sclk;
    assign mosi = r_mosi;
    assign ss   = r_ss;

    always_comb begin
        data_out = '0;
        if (w_rd) begin
            case (address)
                A_CTRL:  data_out = w_ctrl;
                A_DIV:   data_out = DATA_W'(r_div);
                A_RX:    data_out = r_rx;
                A_STAT:  data_out = DATA_W'({r_overrun, r_rx_valid, w_busy});
                A_LEN:   data_out = r_len;
                default: data_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_srst) begin
            r_state    <= IDLE;
            r_sclk     <= 1'b0;
            r_ss       <= '1;
            r_mosi     <= 1'b0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_ss_idx   <= '0;
            r_div      <= '0;
            r_len      <= '0;
            r_rx       <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_cnt      <= '0;
            r_edges    <= '0;
            r_len_eff  <= '0;
            r_tx       <= '0;
            r_rx_sh    <= '0;
`ifdef SPI_LOOPBACK_EN
            r_loop     <= 1'b0;
`endif
        end else begin
            if (w_rd && address == A_RX) begin
                r_rx_valid <= 1'b0;
                r_overrun  <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_sclk <= r_cpol;
                    if (w_wr) begin
                        case (address)
                            A_CTRL: begin
                                r_cpol   <= data_in[0];
                                r_cpha   <= data_in[1];
                                r_lsb    <= data_in[2];
                                r_ss_idx <= data_in[7:4];
`ifdef SPI_LOOPBACK_EN
                                r_loop   <= data_in[3];
`endif
                            end
                            A_DIV: r_div <= DIV_W'(data_in);
                            A_LEN: r_len <= data_in;
                            A_TX: begin
                                r_state   <= SETUP;
                                r_ss      <= ~(N_SS'(1) << w_ss_idx);
                                r_cnt     <= r_div;
                                r_edges   <= '0;
                                r_len_eff <= w_len;
                                r_rx_sh   <= '0;
                                if (!r_cpha) begin
                                    r_mosi <= w_first;
                                    r_tx   <= r_lsb ? (w_tx_init >> 1) : (w_tx_init << 1);
                                end else begin
                                    r_tx   <= w_tx_init;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                SETUP, XFER: begin
                    if (!w_half_end) begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end else begin
                        r_cnt <= r_div;
                        if (r_state == XFER && w_last) begin
                            r_state    <= HOLD;
                            r_rx       <= w_rx_aligned;
                            r_rx_valid <= 1'b1;
                            r_overrun  <= r_overrun | r_rx_valid;
                        end else begin
                            r_state <= XFER;
                            r_sclk  <= ~r_sclk;
                            r_edges <= w_edge_no;
                            if (w_sample) begin
                                r_rx_sh <= r_lsb ? {w_rx_in, r_rx_sh[DATA_W-1:1]}
                                                 : {r_rx_sh[DATA_W-2:0], w_rx_in};
                            end else begin
                                r_mosi <= w_tx_bit;
                                r_tx   <= w_tx_next;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!w_half_end) begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end else begin
                        r_state <= IDLE;
                        r_ss    <= '1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: a small SPI slave model supplies miso and
// records mosi on its sampling edges; bus reads are checked against hand-computed values.
module tb_spi_master_param;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [2:0]  address;
    logic        sel, read, write;
    logic        sclk;
    logic [3:0]  ss;
    logic        mosi;
    logic        miso = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    spi_master_param #(.DATA_W(32), .ADDR_W(3), .N_SS(4), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out),
        .address(address), .sel(sel), .read(read), .write(write),
        .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    // slave model settings
    logic        tb_cpol = 1'b0, tb_cpha = 1'b0, tb_lsb = 1'b0;
    int          tb_len  = 8;
    logic [31:0] tb_miso_w = 32'h0;
    logic [31:0] mosi_q = 32'h0;
    int          mosi_n = 0;
    int          s_idx  = 0;
    logic [3:0]  prev_ss = 4'hF;
    logic        prev_sclk = 1'b0;

    function automatic logic slv_bit(input int i);
        if (i >= tb_len) return 1'b0;
        return tb_lsb ? tb_miso_w[i] : tb_miso_w[tb_len-1-i];
    endfunction

    always @(ss or sclk) begin
        if (!$isunknown(ss) && ss != 4'hF && prev_ss == 4'hF) begin
            mosi_q = 32'h0;
            mosi_n = 0;
            s_idx  = 0;
            if (!tb_cpha) begin
                miso  = slv_bit(0);
                s_idx = 1;
            end
        end else if (!$isunknown(ss) && ss != 4'hF && !$isunknown(sclk) && sclk != prev_sclk) begin
            if (sclk == ~(tb_cpol ^ tb_cpha)) begin
                mosi_q = {mosi_q[30:0], mosi};
                mosi_n++;
            end else begin
                miso  = slv_bit(s_idx);
                s_idx++;
            end
        end
        prev_ss   = ss;
        prev_sclk = sclk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; write = 1'b1; read = 1'b0; address = a; data_in = d;
        @(negedge clk);
        sel = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; read = 1'b1; write = 1'b0; address = a;
        #1 d = data_out;
        @(negedge clk);
        sel = 1'b0; read = 1'b0;
    endtask

    // Launch a word and poll STATUS until ss releases; optionally poke TX/DIV mid-flight.
    task automatic xfer(input logic [31:0] tx, input bit inj,
                        output int n_ss, output int n_busy, output logic [3:0] ss_first);
        n_ss = 0; n_busy = 0; ss_first = 4'hF;
        wr(3'd2, tx);
        for (int c = 0; c < 3000; c++) begin
            write = 1'b0; read = 1'b1; sel = 1'b1; address = 3'd4;
            if (inj && c == 4) begin read = 1'b0; write = 1'b1; address = 3'd2; data_in = 32'hFF; end
            if (inj && c == 8) begin read = 1'b0; write = 1'b1; address = 3'd1; data_in = 32'h7; end
            #1;
            if (ss != 4'hF) begin
                if (n_ss == 0) ss_first = ss;
                n_ss++;
            end
            if (read && data_out[0]) n_busy++;
            if (ss == 4'hF && n_ss > 0) break;
            @(negedge clk);
        end
        sel = 1'b0; read = 1'b0; write = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          nss, nbusy;
        logic [3:0]  ssf;

        sel = 1'b0; read = 1'b0; write = 1'b0; address = '0; data_in = '0; rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_ss", 32'(ss), 32'hF);
        chk("rst_sclk", 32'(sclk), 32'h0);
        chk("rst_mosi", 32'(mosi), 32'h0);
        rd(3'd0, d); chk("rst_ctrl", d, 32'h0);
        rd(3'd4, d); chk("rst_status", d, 32'h0);
        rd(3'd3, d); chk("rst_rx", d, 32'h0);
        rd(3'd1, d); chk("rst_div", d, 32'h0);

        // mode 0, DIV=1, LEN=8, MSB first
        wr(3'd0, 32'h0); wr(3'd1, 32'h1); wr(3'd5, 32'h8);
        rd(3'd1, d); chk("div_rb", d, 32'h1);
        rd(3'd5, d); chk("len_rb", d, 32'h8);
        tb_cpol = 0; tb_cpha = 0; tb_lsb = 0; tb_len = 8; tb_miso_w = 32'h3C;
        xfer(32'hA5, 1'b0, nss, nbusy, ssf);
        chk("m0_busy", 32'(nbusy), 32'd36);
        chk("m0_ss_cnt", 32'(nss), 32'd36);
        chk("m0_ss_sel", 32'(ssf), 32'hE);
        chk("m0_nbits", 32'(mosi_n), 32'd8);
        chk("m0_mosi", mosi_q, 32'hA5);
        rd(3'd4, d); chk("m0_stat", d, 32'h2);
        rd(3'd3, d); chk("m0_rx", d, 32'h3C);
        rd(3'd4, d); chk("m0_stat_clr", d, 32'h0);
        rd(3'd2, d); chk("tx_rd_zero", d, 32'h0);
        rd(3'd7, d); chk("unmapped_zero", d, 32'h0);

        // CPOL=1 CPHA=1 LSB first, LEN=4, SS_IDX=2
        wr(3'd0, 32'h27); wr(3'd5, 32'h4);
        tb_cpol = 1; tb_cpha = 1; tb_lsb = 1; tb_len = 4; tb_miso_w = 32'hC;
        chk("m3_sclk_idle", 32'(sclk), 32'h1);
        xfer(32'h6, 1'b0, nss, nbusy, ssf);
        chk("m3_busy", 32'(nbusy), 32'd20);
        chk("m3_ss_sel", 32'(ssf), 32'hB);
        chk("m3_mosi", mosi_q, 32'h6);
        chk("m3_sclk_after", 32'(sclk), 32'h1);
        rd(3'd4, d); chk("m3_stat", d, 32'h2);

        // second word without reading RX, SS_IDX=5 clamps to 0
        wr(3'd0, 32'h57);
        tb_miso_w = 32'h3;
        xfer(32'hE, 1'b0, nss, nbusy, ssf);
        chk("ovr_ss_clamp", 32'(ssf), 32'hE);
        chk("ovr_mosi", mosi_q, 32'h7);
        rd(3'd4, d); chk("ovr_stat", d, 32'h6);
        rd(3'd3, d); chk("ovr_rx", d, 32'h3);
        rd(3'd4, d); chk("ovr_stat_clr", d, 32'h0);

        // TX and DIV writes while busy are ignored
        wr(3'd0, 32'h0); wr(3'd5, 32'h8);
        tb_cpol = 0; tb_cpha = 0; tb_lsb = 0; tb_len = 8; tb_miso_w = 32'h3C;
        xfer(32'hA5, 1'b1, nss, nbusy, ssf);
        chk("inj_ss_cnt", 32'(nss), 32'd36);
        chk("inj_mosi", mosi_q, 32'hA5);
        repeat (5) @(negedge clk);
        chk("inj_no_restart", 32'(ss), 32'hF);
        rd(3'd1, d); chk("inj_div", d, 32'h1);
        rd(3'd3, d); chk("inj_rx", d, 32'h3C);

        // LEN=0 means a full 32-bit word, DIV=0
        wr(3'd1, 32'h0); wr(3'd5, 32'h0);
        tb_len = 32; tb_miso_w = 32'h12345678;
        xfer(32'hCAFEF00D, 1'b0, nss, nbusy, ssf);
        chk("w32_busy", 32'(nbusy), 32'd66);
        chk("w32_nbits", 32'(mosi_n), 32'd32);
        chk("w32_mosi", mosi_q, 32'hCAFEF00D);
        rd(3'd3, d); chk("w32_rx", d, 32'h12345678);

`ifdef SPI_LOOPBACK_EN
        wr(3'd0, 32'h8);
        rd(3'd0, d); chk("loop_ctrl", d, 32'h8);
        tb_miso_w = 32'h0;
        xfer(32'hDEADBEEF, 1'b0, nss, nbusy, ssf);
        chk("loop_mosi", mosi_q, 32'hDEADBEEF);
        rd(3'd3, d); chk("loop_rx", d, 32'hDEADBEEF);
`else
        wr(3'd0, 32'h8);
        rd(3'd0, d); chk("noloop_ctrl", d, 32'h0);
`endif

        // soft reset while idle, then mid-transfer with CPOL=1
        wr(3'd6, 32'h0);
        rd(3'd3, d); chk("srst_rx", d, 32'h0);
        rd(3'd5, d); chk("srst_len", d, 32'h0);
        wr(3'd0, 32'h1); wr(3'd1, 32'h1); wr(3'd5, 32'h8);
        tb_cpol = 1; tb_cpha = 0; tb_len = 8; tb_miso_w = 32'hFF;
        chk("ab_sclk_idle", 32'(sclk), 32'h1);
        wr(3'd2, 32'hA5);
        repeat (8) @(negedge clk);
        chk("ab_active", 32'(ss), 32'hE);
        wr(3'd6, 32'h0);
        chk("ab_ss", 32'(ss), 32'hF);
        chk("ab_sclk", 32'(sclk), 32'h0);
        rd(3'd4, d); chk("ab_stat", d, 32'h0);
        rd(3'd3, d); chk("ab_rx", d, 32'h0);
        rd(3'd0, d); chk("ab_ctrl", d, 32'h0);
        repeat (50) @(negedge clk);
        rd(3'd3, d); chk("ab_rx_late", d, 32'h0);
        rd(3'd4, d); chk("ab_stat_late", d, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
